// File: rtl/chol_recon_2.sv
// rtl/chol_recon_2.sv - 2x2 Cholesky reconstruction A = L*L^T on one shared pipelined multiplier
//
// Ports:
//   clk      - clock, all logic on posedge
//   rst      - asynchronous active-high reset
//   clk_en   - global enable; low freezes every register
//   L        - packed factor Q16.16: [31:0]=L11, [63:32]=L21, [95:64]=L22
//   L_valid  - L valid this cycle; sampled only while idle
//   busy     - high from the accepting edge until the A_valid edge
//   A        - packed result Q16.16: [31:0]=A11, [63:32]=A21, [95:64]=A22
//   A_valid  - one-enabled-cycle result pulse; A holds until the next result

module chol_recon_2 #(
    parameter int MULT_LATENCY = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_en,
    input  logic [95:0] L,
    input  logic        L_valid,
    output logic        busy,
    output logic [95:0] A,
    output logic        A_valid
);

    localparam int LATENCY = MULT_LATENCY + 6;
    localparam int CW      = $clog2(MULT_LATENCY + 4) + 1;

    // Counter value seen just before the edge that captures product k.
    localparam logic [CW-1:0] C_ISSUE_LAST = CW'(3);
    localparam logic [CW-1:0] C_P0         = CW'(MULT_LATENCY);
    localparam logic [CW-1:0] C_P1         = CW'(MULT_LATENCY + 1);
    localparam logic [CW-1:0] C_P2         = CW'(MULT_LATENCY + 2);
    localparam logic [CW-1:0] C_P3         = CW'(MULT_LATENCY + 3);

    typedef enum logic [4:0] {
        S_IDLE  = 5'b00001,
        S_ISSUE = 5'b00010,
        S_DRAIN = 5'b00100,
        S_SUM   = 5'b01000,
        S_DONE  = 5'b10000
    } state_t;

    state_t state, state_nxt;

    logic [CW-1:0]      cnt;
    logic [95:0]        l_q;
    logic signed [31:0] op_a;
    logic signed [31:0] op_b;
    logic signed [63:0] prod_comb;
    logic signed [63:0] mult_out;
    logic [31:0]        p2_q;
    logic [31:0]        p3_q;
    logic [31:0]        sum_q;
    logic signed [32:0] sum33;

    // Q32.32 product -> Q16.16, truncated, saturating when bits 63..47 disagree.
    function automatic logic [31:0] sat_prod(input logic [63:0] p);
        if ((&p[63:47]) || !(|p[63:47]))
            return p[47:16];
        else
            return p[63] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    endfunction

    function automatic logic [31:0] sat_sum(input logic [32:0] s);
        if (s[32] == s[31])
            return s[31:0];
        else
            return s[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    endfunction

    assign prod_comb = $signed({{32{op_a[31]}}, op_a}) * $signed({{32{op_b[31]}}, op_b});
    assign sum33     = $signed({p2_q[31], p2_q}) + $signed({p3_q[31], p3_q});

    // Multiplier: operand registers plus MULT_LATENCY-1 product stages, so a
    // product loaded at edge Ek is ready to be captured at edge Ek+MULT_LATENCY.
    generate
        if (MULT_LATENCY == 1) begin : g_comb
            assign mult_out = prod_comb;
        end else begin : g_pipe
            logic signed [63:0] pipe [MULT_LATENCY-1];
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < MULT_LATENCY - 1; i++) pipe[i] <= '0;
                end else if (clk_en) begin
                    pipe[0] <= prod_comb;
                    for (int i = 1; i < MULT_LATENCY - 1; i++) pipe[i] <= pipe[i-1];
                end
            end
            assign mult_out = pipe[MULT_LATENCY-2];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_IDLE;
        else if (clk_en)
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (L_valid) state_nxt = S_ISSUE;
            S_ISSUE: if (cnt == C_ISSUE_LAST) state_nxt = S_DRAIN;
            S_DRAIN: if (cnt == C_P3) state_nxt = S_SUM;
            S_SUM:   state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            l_q     <= '0;
            op_a    <= '0;
            op_b    <= '0;
            p2_q    <= '0;
            p3_q    <= '0;
            sum_q   <= '0;
            busy    <= 1'b0;
            A       <= '0;
            A_valid <= 1'b0;
        end else if (clk_en) begin
            A_valid <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (L_valid) begin
                        l_q  <= L;
                        busy <= 1'b1;
                        cnt  <= '0;
                    end
                end
                S_ISSUE: begin
                    case (cnt[1:0])
                        2'd0: begin op_a <= l_q[31:0];  op_b <= l_q[31:0];  end
                        2'd1: begin op_a <= l_q[63:32]; op_b <= l_q[31:0];  end
                        2'd2: begin op_a <= l_q[63:32]; op_b <= l_q[63:32]; end
                        default: begin op_a <= l_q[95:64]; op_b <= l_q[95:64]; end
                    endcase
                end
                S_SUM: begin
                    sum_q <= sat_sum(sum33);
                end
                S_DONE: begin
                    A[95:64] <= sum_q;
                    A_valid  <= 1'b1;
                    busy     <= 1'b0;
                end
                default: ;
            endcase

            // Product capture is keyed on the job counter rather than the state,
            // so short multiplier latencies may retire products during S_ISSUE.
            if (state == S_ISSUE || state == S_DRAIN) begin
                cnt <= cnt + 1'b1;
                if (cnt == C_P0) A[31:0]  <= sat_prod(mult_out);
                if (cnt == C_P1) A[63:32] <= sat_prod(mult_out);
                if (cnt == C_P2) p2_q     <= sat_prod(mult_out);
                if (cnt == C_P3) p3_q     <= sat_prod(mult_out);
            end
        end
    end

endmodule

// File: tb/tb_chol_recon_2.sv
// tb/tb_chol_recon_2.sv - directed self-checking bench for chol_recon_2

module tb_chol_recon_2;

    localparam int ML  = 6;
    localparam int LAT = ML + 6;

    localparam logic [95:0] V1     = {32'h0003_0000, 32'h0001_0000, 32'h0002_0000};
    localparam logic [95:0] V1_EXP = {32'h000A_0000, 32'h0002_0000, 32'h0004_0000};
    localparam logic [95:0] V2     = {32'h0000_8000, 32'hFFFE_8000, 32'h0002_0000};
    localparam logic [95:0] V2_EXP = {32'h0002_8000, 32'hFFFD_0000, 32'h0004_0000};
    localparam logic [95:0] V3     = {32'h7FFF_0000, 32'h7FFF_0000, 32'h7FFF_0000};
    localparam logic [95:0] V3_EXP = {32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF};

    logic        clk = 1'b0;
    logic        rst;
    logic        clk_en;
    logic [95:0] L;
    logic        L_valid;
    logic        busy;
    logic [95:0] A;
    logic        A_valid;

    int total = 0;
    int fails = 0;

    chol_recon_2 #(.MULT_LATENCY(ML)) dut (
        .clk     (clk),
        .rst     (rst),
        .clk_en  (clk_en),
        .L       (L),
        .L_valid (L_valid),
        .busy    (busy),
        .A       (A),
        .A_valid (A_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [95:0] v);
        @(negedge clk);
        L       = v;
        L_valid = 1'b1;
        @(posedge clk);
        #1;
        L_valid = 1'b0;
    endtask

    // Edges counted from the previous sampling point until A_valid is seen; -1 on timeout.
    task automatic wait_valid(output int n);
        n = -1;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk);
            #1;
            if (A_valid) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic count_pulses(input int cycles, output int c);
        c = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (A_valid) c++;
        end
    endtask

    initial begin
        int n;
        int c;
        rst     = 1'b1;
        clk_en  = 1'b1;
        L       = '0;
        L_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 96'(busy), 96'(0));
        chk("reset_A", A, 96'(0));
        chk("reset_A_valid", 96'(A_valid), 96'(0));
        @(negedge clk);
        rst = 1'b0;

        // Vector 1: basic result and exact latency
        send(V1);
        chk("v1_busy_after_e0", 96'(busy), 96'(1));
        wait_valid(n);
        chk("v1_latency", 96'(n), 96'(LAT));
        chk("v1_A", A, V1_EXP);
        chk("v1_busy_done", 96'(busy), 96'(0));

        // Vector 2 offered in the A_valid cycle (state idle) is accepted
        L       = V2;
        L_valid = 1'b1;
        @(posedge clk);
        #1;
        L_valid = 1'b0;
        chk("v2_pulse_one_cycle", 96'(A_valid), 96'(0));
        chk("v2_accepted_busy", 96'(busy), 96'(1));
        wait_valid(n);
        chk("v2_latency", 96'(n), 96'(LAT));
        chk("v2_A", A, V2_EXP);

        // Vector 3: product and sum saturation
        send(V3);
        wait_valid(n);
        chk("v3_A_sat", A, V3_EXP);

        // Second L_valid while busy is dropped; L changes after E0 do not matter
        send(V2);
        @(posedge clk);
        #1;
        L       = V1;
        L_valid = 1'b1;
        @(posedge clk);
        #1;
        L_valid = 1'b0;
        wait_valid(n);
        chk("busy_drop_latency", 96'(n), 96'(LAT - 2));
        chk("busy_drop_A", A, V2_EXP);
        count_pulses(20, c);
        chk("busy_drop_no_extra", 96'(c), 96'(0));

        // clk_en low for 5 cycles in S_DRAIN stretches latency
        send(V1);
        repeat (6) @(posedge clk);
        #1;
        clk_en = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        clk_en = 1'b1;
        wait_valid(n);
        chk("stall_latency", 96'(n + 11), 96'(ML + 11));
        chk("stall_A", A, V1_EXP);
        clk_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("stall_pulse_held", 96'(A_valid), 96'(1));
        clk_en = 1'b1;
        @(posedge clk);
        #1;
        chk("stall_pulse_drop", 96'(A_valid), 96'(0));

        // Reset during S_ISSUE aborts the job
        send(V3);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("abort_busy", 96'(busy), 96'(0));
        chk("abort_A", A, 96'(0));
        chk("abort_A_valid", 96'(A_valid), 96'(0));
        @(negedge clk);
        rst = 1'b0;
        count_pulses(20, c);
        chk("abort_no_pulse", 96'(c), 96'(0));
        send(V1);
        wait_valid(n);
        chk("after_abort_latency", 96'(n), 96'(LAT));
        chk("after_abort_A", A, V1_EXP);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
